serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's single-bit half/full adder and subtractor cells. A start/ready handshake accepts two WIDTH-bit operands plus a mode. The block then processes one bit per clock, LSB first, through a one-bit full-add/full-subtract datapath. It returns the result with carry/borrow, signed-overflow and zero flags, and pulses done.

---
 rtl/serial_addsub.sv | 91 +++++++++
 tb/tb_serial_addsub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one bit per clock behind a start/ready handshake.
module serial_addsub #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       mode,
  input  logic             cbIn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cbOut,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d, result_q;
  logic sub_q, cb_q, cb_d, cbout_q, ovf_q, zero_q, done_q;
  logic ai, bi, x, s, accept, last;
  assign ai = a_q[0];
  assign bi = b_q[0];
  assign x = ai ^ bi;
  assign s = x ^ cb_q;
  assign cb_d = sub_q ? ((~ai & bi) | (~x & cb_q)) : ((ai & bi) | (x & cb_q));
  assign r_d = {s, r_q[WIDTH-1:1]};
  assign accept = (state_q == IDLE) && start;
  assign last = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (accept) state_d = RUN;
    else if (last) state_d = IDLE;
  end
  always_comb begin
    ready = (state_q == IDLE);
    busy = (state_q == RUN);
  end
  // Operands shift right so bit i is always at position 0; result fills from the MSB end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      sub_q <= 1'b0;
      cb_q <= 1'b0;
      result_q <= '0;
      cbout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        sub_q <= mode[0];
        cb_q <= mode[1] & cbIn;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        r_q <= r_d;
        cb_q <= cb_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Signed overflow is carry (borrow) into the MSB xor carry (borrow) out of it.
      if (last) begin
        result_q <= r_d;
        cbout_q <= cb_d;
        ovf_q <= cb_q ^ cb_d;
        zero_q <= (r_d == '0);
      end
    end
  end
  assign result = result_q;
  assign cbOut = cbout_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
  assign done = done_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of serial_addsub at WIDTH=8 plus an exhaustive sweep at WIDTH=4.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start8 = 1'b0, cbin8 = 1'b0;
  logic [1:0] mode8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ready8, cbout8, ovf8, zero8, busy8, done8;
  logic [7:0] result8;
  logic start4 = 1'b0, cbin4 = 1'b0;
  logic [1:0] mode4 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic ready4, cbout4, ovf4, zero4, busy4, done4;
  logic [3:0] result4;
  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ready(ready8), .mode(mode8), .cbIn(cbin8),
    .a(a8), .b(b8), .result(result8), .cbOut(cbout8), .ovf(ovf8), .zero(zero8),
    .busy(busy8), .done(done8)
  );
  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ready(ready4), .mode(mode4), .cbIn(cbin4),
    .a(a4), .b(b4), .result(result4), .cbOut(cbout4), .ovf(ovf4), .zero(zero4),
    .busy(busy4), .done(done4)
  );

  task automatic check_idle(input string nm);
    tests++;
    if ({ready8, busy8, done8, result8, cbout8, ovf8, zero8} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL %s: rdy=%b busy=%b done=%b res=%h c=%b o=%b z=%b, want rdy=1 rest 0",
               nm, ready8, busy8, done8, result8, cbout8, ovf8, zero8);
    end
  endtask

  task automatic run8(input string nm, input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic [7:0] er, input logic ec, input logic eo, input logic ez);
    int n;
    @(negedge clk);
    mode8 = m; a8 = av; b8 = bv; cbin8 = ci; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = ~av; b8 = 8'h5A; mode8 = ~m; cbin8 = ~ci;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (!done8 || n != 8 || !ready8) begin
      fails++;
      $display("FAIL %s latency: done=%b ready=%b after %0d edges, want done=1 ready=1 after 8", nm, done8, ready8, n);
    end
    tests++;
    if ({result8, cbout8, ovf8, zero8} !== {er, ec, eo, ez}) begin
      fails++;
      $display("FAIL %s: res=%h c=%b o=%b z=%b, want res=%h c=%b o=%b z=%b",
               nm, result8, cbout8, ovf8, zero8, er, ec, eo, ez);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done8 !== 1'b0 || result8 !== er) begin
      fails++;
      $display("FAIL %s pulse: done=%b res=%h next cycle, want done=0 res=%h", nm, done8, result8, er);
    end
  endtask

  task automatic test_reset;
    #2;
    check_idle("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_add;
    run8("add_7f_01", 2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub;
    run8("sub_00_01", 2'b01, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8("sub_05_05", 2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_carry_in;
    run8("adc_ff_00", 2'b10, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    run8("sbb_80_00", 2'b11, 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8("add_ci_ign", 2'b00, 8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] ea [3] = '{8'h11, 8'h50, 8'hA0};
    logic [7:0] eb [3] = '{8'h22, 8'h30, 8'h70};
    logic [1:0] em [3] = '{2'b00, 2'b01, 2'b00};
    logic [7:0] er [3] = '{8'h33, 8'h20, 8'h10};
    logic       ec [3] = '{1'b0, 1'b0, 1'b1};
    int k, n, t0, tp;
    @(negedge clk);
    a8 = ea[0]; b8 = eb[0]; mode8 = em[0]; cbin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc; tp = cyc; k = 0; n = 0;
    while (k < 3 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (done8) begin
        tests++;
        if (result8 !== er[k] || cbout8 !== ec[k]) begin
          fails++;
          $display("FAIL b2b_op%0d: res=%h c=%b, want res=%h c=%b", k, result8, cbout8, er[k], ec[k]);
        end
        tests++;
        if ((cyc - tp) != (k == 0 ? 8 : 9)) begin
          fails++;
          $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", k, cyc - tp, k == 0 ? 8 : 9);
        end
        tp = cyc;
        k++;
        if (k < 3) begin
          a8 = ea[k]; b8 = eb[k]; mode8 = em[k];
        end else start8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom); cbin8 = 1'($urandom);
      end
    end
    tests++;
    if (k != 3) begin
      fails++;
      $display("FAIL b2b_count: %0d done pulses from t=%0d, want 3", k, t0);
    end
    start8 = 1'b0; cbin8 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; mode8 = 2'b00; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle("reset_mid_run");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) seen++;
    end
    tests++;
    if (seen != 0 || result8 !== 8'h00) begin
      fails++;
      $display("FAIL reset_no_done: %0d done pulses res=%h, want 0 pulses res=00", seen, result8);
    end
    run8("after_reset", 2'b00, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_exhaustive_w4;
    logic [5:0] s;
    logic [3:0] er;
    logic ec, eo, ez, cie;
    int n;
    for (int m = 0; m < 4; m++)
      for (int ci = 0; ci < 2; ci++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++) begin
            cie = m[1] & ci[0];
            s = m[0] ? 6'(av) - 6'(bv) - 6'(cie) : 6'(av) + 6'(bv) + 6'(cie);
            er = s[3:0];
            ec = m[0] ? s[5] : s[4];
            eo = m[0] ? (av[3] != bv[3]) && (er[3] != av[3]) : (av[3] == bv[3]) && (er[3] != av[3]);
            ez = (er == 4'h0);
            @(negedge clk);
            mode4 = 2'(m); cbin4 = ci[0]; a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1;
            @(posedge clk);
            #1;
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 10) begin
              @(posedge clk);
              #1;
              n++;
            end
            tests++;
            if (!done4 || n != 4 || {result4, cbout4, ovf4, zero4} !== {er, ec, eo, ez}) begin
              fails++;
              $display("FAIL w4 m=%0d ci=%0d a=%h b=%h: done=%b edges=%0d res=%h c=%b o=%b z=%b, want edges=4 res=%h c=%b o=%b z=%b",
                       m, ci, av, bv, done4, n, result4, cbout4, ovf4, zero4, er, ec, eo, ez);
            end
          end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_in();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_w4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
